elevator_car_plant: RTL and testbench
=====================================

Name: elevator_car_plant

Overview:
- Behavioural car/shaft model for the elevator control path. It is the other end of the controller interface: it consumes motor_up, motor_down and door_open, and produces current_floor.
- Travel between floors takes a fixed number of clock ticks. Door dwell takes a fixed number of ticks.
- Illegal command combinations are flagged with a sticky fault.
- Used in closed-loop simulation and on FPGA demo boards in place of a real shaft encoder.

Parameters:
- NUM_FLOORS, 4: number of floors (2..2^FLOOR_W); floors are numbered 0..NUM_FLOORS-1.
- FLOOR_W, 2: width of current_floor.
- TICKS_PER_FLOOR, 8: active travel cycles needed to move one floor (must be >= 2).
- DOOR_TICKS, 4: cycles door_is_open stays high per door cycle (must be >= 1).
- CNT_W, 8: width of the travel and door counters; must hold max(TICKS_PER_FLOOR, DOOR_TICKS).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- motor_up  in  1  drive car upward while high.
- motor_down  in  1  drive car downward while high.
- door_open  in  1  request a door cycle; level sampled only in STOPPED.
- current_floor  out  FLOOR_W  registered floor position.
- moving  out  1  high in TRAVEL_UP or TRAVEL_DOWN.
- door_is_open  out  1  high for the DOOR_TICKS-cycle door window.
- arrived  out  1  one-cycle pulse in the cycle current_floor changes.
- fault  out  1  sticky error flag.

Behaviour:
- All outputs are registered. Reset (clk and reset as given: reset asynchronous, active-high; clock clk) forces:
  - state=STOPPED, travel_cnt=0, door_cnt=0;
  - current_floor=0, moving=0, door_is_open=0, arrived=0, fault=0.
  - Reset mid-travel or mid-door discards all progress.
- States: STOPPED, TRAVEL_UP, TRAVEL_DOWN, DOOR_CYCLE, FAULT.
- STOPPED, inputs evaluated each edge in priority order:
  1. motor_up && motor_down -> FAULT.
  2. Any motor && door_open -> FAULT.
  3. motor_up at floor NUM_FLOORS-1, or motor_down at floor 0 -> FAULT (overrun).
  4. motor_up with travel_cnt!=0 and last direction down (or motor_down with last direction up) -> FAULT (reversal between floors).
  5. motor_up -> TRAVEL_UP, and this edge counts as an active tick.
  6. motor_down -> TRAVEL_DOWN, and this edge counts as an active tick.
  7. door_open -> DOOR_CYCLE, door_cnt=1, door_is_open=1.
  8. Otherwise stay in STOPPED.
- TRAVEL_UP / TRAVEL_DOWN:
  - Each edge with the same-direction motor input high and the other low is an active tick.
  - On an active tick: travel_cnt increments. If travel_cnt was TICKS_PER_FLOOR-1, then travel_cnt=0, current_floor +/-1 and arrived=1 on the same edge.
  - After arriving at floor NUM_FLOORS-1 (up) or 0 (down), any further active tick -> FAULT.
  - Both motors high, or door_open high -> FAULT.
  - Motor released -> STOPPED. travel_cnt and last direction are retained, so resuming the same direction continues the partial floor.
- Latency: from STOPPED at floor k with travel_cnt=0, motor_up held gives current_floor=k+1 on the TICKS_PER_FLOOR-th active edge.
- DOOR_CYCLE:
  - door_is_open=1 for exactly DOOR_TICKS cycles, independent of the door_open level after entry.
  - On the DOOR_TICKS-th edge: door_is_open=0, state=STOPPED. If door_open is still high, a new cycle starts on the following edge.
  - Any motor input high -> FAULT.
- FAULT:
  - fault=1, moving=0, door_is_open=0, arrived=0.
  - current_floor and travel_cnt frozen.
  - Exit only via reset, or via fault_clear when the optional feature is enabled.
- arrived is never high for two consecutive cycles when TICKS_PER_FLOOR>=2.
- current_floor never leaves the range 0..NUM_FLOORS-1.

Optional Feature:
- Macro: ELEVATOR_PLANT_FAULT_CLEAR_EN.
- Defined:
  - Adds input fault_clear (1 bit).
  - In FAULT, fault_clear high on an edge gives: state=STOPPED, fault=0, travel_cnt=0, door_cnt=0, current_floor unchanged.
  - fault_clear is ignored in all other states.
- Undefined: no fault_clear port; FAULT is left only by reset.

Test Plan:
- Reset, then motor_up held 16 cycles from floor 0 -> arrived pulses on active edges 8 and 16; current_floor=1 then 2; moving=1 throughout; fault=0.
- Drive up to floor 3, then hold motor_up 1 more cycle -> fault=1, moving=0, current_floor stays 3; reset -> all outputs 0, current_floor=0.
- At floor 2, door_open pulsed for 1 cycle -> door_is_open high for exactly 4 cycles then 0; motor_up asserted during the window -> fault=1.
- From STOPPED, motor_up and motor_down high in the same cycle -> fault=1 next edge and stays 1 with inputs idle for 20 cycles.
- motor_up 3 cycles, idle 2 cycles, motor_up 5 cycles -> current_floor 0->1 on the 8th active edge, and not before; in a repeat run, motor_down after the 3 up-ticks -> fault=1.
- motor_up for 5 cycles, then reset asserted asynchronously mid-cycle -> outputs 0 immediately; after release, 8 more up-ticks are needed to reach floor 1. With ELEVATOR_PLANT_FAULT_CLEAR_EN: force a fault at floor 1, pulse fault_clear -> fault=0, current_floor=1, and 8 up-ticks are needed to reach floor 2.

Source files
------------

// File: rtl/elevator_car_plant_if.sv
// rtl/elevator_car_plant_if.sv - Controller-to-car-plant signal bundle.
// fault_clear exists only when ELEVATOR_PLANT_FAULT_CLEAR_EN is defined.
interface elevator_car_plant_if #(
  parameter int FLOOR_W = 2
);
  logic               motor_up;
  logic               motor_down;
  logic               door_open;
`ifdef ELEVATOR_PLANT_FAULT_CLEAR_EN
  logic               fault_clear;
`endif
  logic [FLOOR_W-1:0] current_floor;
  logic               moving;
  logic               door_is_open;
  logic               arrived;
  logic               fault;

  modport master (
    output motor_up, motor_down, door_open,
`ifdef ELEVATOR_PLANT_FAULT_CLEAR_EN
    output fault_clear,
`endif
    input  current_floor, moving, door_is_open, arrived, fault
  );

  modport slave (
    input  motor_up, motor_down, door_open,
`ifdef ELEVATOR_PLANT_FAULT_CLEAR_EN
    input  fault_clear,
`endif
    output current_floor, moving, door_is_open, arrived, fault
  );
endinterface

// File: rtl/elevator_car_plant.sv
// rtl/elevator_car_plant.sv - Behavioural car/shaft model driven by motor and door commands.
// Optional fault recovery input enabled by ELEVATOR_PLANT_FAULT_CLEAR_EN.
module elevator_car_plant #(
  parameter int NUM_FLOORS      = 4,
  parameter int FLOOR_W         = 2,
  parameter int TICKS_PER_FLOOR = 8,
  parameter int DOOR_TICKS      = 4,
  parameter int CNT_W           = 8
) (
  input logic                 clk,
  input logic                 reset,
  elevator_car_plant_if.slave bus
);
  typedef enum logic [2:0] {STOPPED, TRAVEL_UP, TRAVEL_DOWN, DOOR_CYCLE, FAULT} state_t;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TICKS_PER_FLOOR - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_TICKS);

  state_t             state;
  logic [CNT_W-1:0]   travel_cnt;
  logic [CNT_W-1:0]   door_cnt;
  logic               last_up;
  logic [FLOOR_W-1:0] floor_q;
  logic               moving_q;
  logic               door_q;
  logic               arrived_q;
  logic               fault_q;

  logic up, down, door, wrap, to_fault, tick;

  assign up   = bus.motor_up;
  assign down = bus.motor_down;
  assign door = bus.door_open;
  assign wrap = (travel_cnt == TRAVEL_LAST);

  assign bus.current_floor = floor_q;
  assign bus.moving        = moving_q;
  assign bus.door_is_open  = door_q;
  assign bus.arrived       = arrived_q;
  assign bus.fault         = fault_q;

  // Classify this edge: illegal command (to_fault) or a travel tick in the commanded direction.
  always_comb begin
    to_fault = 1'b0;
    tick     = 1'b0;
    case (state)
      STOPPED: begin
        if (up && down)
          to_fault = 1'b1;
        else if ((up || down) && door)
          to_fault = 1'b1;
        else if ((up && floor_q == TOP_FLOOR) || (down && floor_q == '0))
          to_fault = 1'b1;
        else if (travel_cnt != '0 && ((up && !last_up) || (down && last_up)))
          to_fault = 1'b1;
        else
          tick = up || down;
      end
      TRAVEL_UP: begin
        if ((up && down) || door)
          to_fault = 1'b1;
        else if (up) begin
          if (floor_q == TOP_FLOOR) to_fault = 1'b1;
          else                      tick     = 1'b1;
        end
      end
      TRAVEL_DOWN: begin
        if ((up && down) || door)
          to_fault = 1'b1;
        else if (down) begin
          if (floor_q == '0) to_fault = 1'b1;
          else               tick     = 1'b1;
        end
      end
      DOOR_CYCLE: to_fault = up || down;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STOPPED;
      travel_cnt <= '0;
      door_cnt   <= '0;
      last_up    <= 1'b0;
      floor_q    <= '0;
      moving_q   <= 1'b0;
      door_q     <= 1'b0;
      arrived_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      arrived_q <= 1'b0;
      if (to_fault) begin
        state    <= FAULT;
        fault_q  <= 1'b1;
        moving_q <= 1'b0;
        door_q   <= 1'b0;
      end else if (tick) begin
        state      <= up ? TRAVEL_UP : TRAVEL_DOWN;
        moving_q   <= 1'b1;
        last_up    <= up;
        travel_cnt <= wrap ? '0 : travel_cnt + CNT_W'(1);
        if (wrap) begin
          floor_q   <= up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          arrived_q <= 1'b1;
        end
      end else begin
        case (state)
          STOPPED: begin
            if (door) begin
              state    <= DOOR_CYCLE;
              door_cnt <= CNT_W'(1);
              door_q   <= 1'b1;
            end
          end
          // Released motor keeps travel_cnt/last_up so a same-direction resume continues the floor.
          TRAVEL_UP, TRAVEL_DOWN: begin
            state    <= STOPPED;
            moving_q <= 1'b0;
          end
          DOOR_CYCLE: begin
            if (door_cnt == DOOR_LAST) begin
              state    <= STOPPED;
              door_cnt <= '0;
              door_q   <= 1'b0;
            end else begin
              door_cnt <= door_cnt + CNT_W'(1);
            end
          end
          FAULT: begin
`ifdef ELEVATOR_PLANT_FAULT_CLEAR_EN
            if (bus.fault_clear) begin
              state      <= STOPPED;
              fault_q    <= 1'b0;
              travel_cnt <= '0;
              door_cnt   <= '0;
            end
`endif
          end
          default: state <= FAULT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_elevator_car_plant.sv
// tb/tb_elevator_car_plant.sv - Vector-table and scoreboard bench for elevator_car_plant.
module tb_elevator_car_plant;
  logic clk = 1'b0;
  logic reset;

  elevator_car_plant_if #(.FLOOR_W(2)) bus ();

  elevator_car_plant #(
    .NUM_FLOORS(4), .FLOOR_W(2), .TICKS_PER_FLOOR(8), .DOOR_TICKS(4), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    rst;
    bit    clr;
    bit    up;
    bit    down;
    bit    door;
    int    floor;
    bit    mv;
    bit    dr;
    bit    arr;
    bit    flt;
    string name;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(bit rst, bit up, bit down, bit door, int floor,
                              bit mv, bit dr, bit arr, bit flt, string name);
    vec_t v;
    v.rst = rst; v.clr = 1'b0; v.up = up; v.down = down; v.door = door;
    v.floor = floor; v.mv = mv; v.dr = dr; v.arr = arr; v.flt = flt; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void add_n(int n, bit up, bit down, bit door, int floor,
                                bit mv, bit dr, bit arr, bit flt, string name);
    for (int i = 0; i < n; i++) add(1'b0, up, down, door, floor, mv, dr, arr, flt, name);
  endfunction

  function automatic logic [5:0] pack_exp(int floor, bit mv, bit dr, bit arr, bit flt);
    logic [1:0] f;
    f = 2'(floor);
    return {f, mv, dr, arr, flt};
  endfunction

  task automatic check_now();
    sb_t e;
    logic [5:0] act;
    act = {bus.current_floor, bus.moving, bus.door_is_open, bus.arrived, bus.fault};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty actual=%b required=entry", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s actual{floor,mv,door,arr,flt}=%b required=%b at %0t",
                 e.name, act, e.exp, $time);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    bus.motor_up   = v.up;
    bus.motor_down = v.down;
    bus.door_open  = v.door;
`ifdef ELEVATOR_PLANT_FAULT_CLEAR_EN
    bus.fault_clear = v.clr;
`endif
    if (v.rst) reset = 1'b1;
    e.exp  = pack_exp(v.floor, v.mv, v.dr, v.arr, v.flt);
    e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_now();
  endtask

  initial begin
    vec_t v;
    sb_t  e;
    reset          = 1'b1;
    bus.motor_up   = 1'b0;
    bus.motor_down = 1'b0;
    bus.door_open  = 1'b0;
`ifdef ELEVATOR_PLANT_FAULT_CLEAR_EN
    bus.fault_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, then 16 up-ticks: arrivals on ticks 8 and 16.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_state");
    for (int i = 1; i <= 16; i++)
      add(0, 1, 0, 0, i / 8, 1, 0, (i % 8) == 0, 0, "up_run");
    add_n(7, 1, 0, 0, 2, 1, 0, 0, 0, "up_to_top");
    add(0, 1, 0, 0, 3, 1, 0, 1, 0, "arrive_top");
    add(0, 1, 0, 0, 3, 0, 0, 0, 1, "overrun_top");
    add(0, 0, 0, 0, 3, 0, 0, 0, 1, "fault_hold_top");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_after_overrun");

    // Door window at floor 2, then motor during window.
    for (int i = 1; i <= 16; i++)
      add(0, 1, 0, 0, i / 8, 1, 0, (i % 8) == 0, 0, "up_to_2");
    add(0, 0, 0, 0, 2, 0, 0, 0, 0, "stop_at_2");
    add(0, 0, 0, 1, 2, 0, 1, 0, 0, "door_enter");
    add_n(3, 0, 0, 0, 2, 0, 1, 0, 0, "door_window");
    add(0, 0, 0, 0, 2, 0, 0, 0, 0, "door_close");
    add(0, 0, 0, 1, 2, 0, 1, 0, 0, "door_reenter");
    add(0, 1, 0, 0, 2, 0, 0, 0, 1, "motor_in_door");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_after_door");

    // Both motors together: sticky fault.
    add(0, 1, 1, 0, 0, 0, 0, 0, 1, "both_motors");
    add_n(20, 0, 0, 0, 0, 0, 0, 0, 1, "fault_sticky");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_after_both");

    // Partial floor resumed after a pause.
    add_n(3, 1, 0, 0, 0, 1, 0, 0, 0, "partial_up");
    add_n(2, 0, 0, 0, 0, 0, 0, 0, 0, "pause");
    add_n(4, 1, 0, 0, 0, 1, 0, 0, 0, "resume_up");
    add(0, 1, 0, 0, 1, 1, 0, 1, 0, "resume_arrive");
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, "stop_at_1");
    // Reversal between floors from floor 1.
    add_n(3, 1, 0, 0, 1, 1, 0, 0, 0, "partial_up2");
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, "pause2");
    add(0, 0, 1, 0, 1, 0, 0, 0, 1, "reversal_fault");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_after_rev");

    // Down travel and bottom overrun.
    add_n(7, 1, 0, 0, 0, 1, 0, 0, 0, "up_for_down");
    add(0, 1, 0, 0, 1, 1, 0, 1, 0, "arrive_1");
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, "stop_before_down");
    add_n(7, 0, 1, 0, 1, 1, 0, 0, 0, "down_run");
    add(0, 0, 1, 0, 0, 1, 0, 1, 0, "arrive_0");
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, "overrun_bottom");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_after_bottom");

    // Motor together with door request.
    add(0, 1, 0, 1, 0, 0, 0, 0, 1, "motor_and_door");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_after_md");

    // Stopped-state overrun at floor 0.
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, "down_at_0");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_after_d0");

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Asynchronous reset mid-travel discards the partial floor.
    for (int i = 0; i < 5; i++) begin
      v = '{rst:0, clr:0, up:1, down:0, door:0, floor:0, mv:1, dr:0, arr:0, flt:0, name:"pre_async"};
      run_vec(v);
    end
    #3 reset = 1'b1;
    #1;
    e.exp = 6'b0; e.name = "async_reset";
    sb.push_back(e);
    check_now();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      v = '{rst:0, clr:0, up:1, down:0, door:0, floor:i / 8, mv:1, dr:0,
            arr:(i == 8), flt:0, name:"after_async"};
      run_vec(v);
    end

`ifdef ELEVATOR_PLANT_FAULT_CLEAR_EN
    v = '{rst:0, clr:0, up:0, down:0, door:0, floor:1, mv:0, dr:0, arr:0, flt:0, name:"fc_stop"};
    run_vec(v);
    v = '{rst:0, clr:0, up:1, down:1, door:0, floor:1, mv:0, dr:0, arr:0, flt:1, name:"fc_fault"};
    run_vec(v);
    v = '{rst:0, clr:1, up:0, down:0, door:0, floor:1, mv:0, dr:0, arr:0, flt:0, name:"fc_clear"};
    run_vec(v);
    for (int i = 1; i <= 8; i++) begin
      v = '{rst:0, clr:0, up:1, down:0, door:0, floor:1 + i / 8, mv:1, dr:0,
            arr:(i == 8), flt:0, name:"fc_resume"};
      run_vec(v);
    end
`endif

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
